// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter driving one 4-phase req/ack CDC channel; ack is synchronized internally.
// Latency: launch 1 cycle after req seen, grant 2+2*SYNC_STAGES cycles best case plus far-side delay.
// Backpressure: requesters hold req until grant; optional abort via XFER_TIMEOUT_EN (err/err_id).
module cdc_xfer_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic                      xfer_req,
    output logic [DATA_W-1:0]         xfer_data,
    input  logic                      xfer_ack_async,
    output logic                      err,
    output logic [$clog2(N_REQ)-1:0]  err_id
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_REQ_HI, S_REQ_LO} state_t;

    if (N_REQ < 2 || N_REQ > 16 || SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("cdc_xfer_arbiter: parameter out of range");
    end

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_ack_sync;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [ID_W-1:0]          r_win_id;
    logic [N_REQ-1:0]         r_grant;
    logic                     r_busy;
    logic                     r_xfer_req;
    logic [DATA_W-1:0]        r_xfer_data;

    logic                     w_ack_s;
    logic [2*N_REQ-1:0]       w_dbl;
    logic [N_REQ-1:0]         w_rot;
    logic                     w_found;
    logic [ID_W:0]            w_sum;
    logic [ID_W-1:0]          w_winner;
    logic [DATA_W-1:0]        w_win_data;
    logic [ID_W-1:0]          w_win_next;
    logic                     w_expire;
    logic                     w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], xfer_ack_async};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
    assign w_dbl = {req, req} >> r_rr_ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_found  = 1'b0;
        w_sum    = '0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(N_REQ)) begin
                    w_sum = w_sum - (ID_W+1)'(N_REQ);
                end
                w_winner = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winner == ID_W'(k)) begin
                w_win_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_win_next = (r_win_id == ID_W'(N_REQ-1)) ? '0 : r_win_id + 1'b1;

`ifdef XFER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;
    logic [ID_W-1:0]  r_err_id;

    assign w_expire = (r_state != S_IDLE) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
            r_err_id  <= '0;
        end else begin
            r_err <= w_abort;
            if (w_abort) begin
                r_err_id <= r_win_id;
            end
            if (r_state == S_IDLE) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign err    = r_err;
    assign err_id = r_err_id;
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
    assign err_id   = '0;
`endif

    // A completion landing on the expiry cycle wins over the abort.
    assign w_abort = w_expire && !(r_state == S_REQ_LO && !w_ack_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_win_id    <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_xfer_req  <= 1'b0;
            r_xfer_data <= '0;
        end else begin
            r_grant <= '0;
            if (w_abort) begin
                r_xfer_req <= 1'b0;
                r_busy     <= 1'b0;
                r_rr_ptr   <= w_win_next;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_found && !w_ack_s) begin
                            r_xfer_data <= w_win_data;
                            r_win_id    <= w_winner;
                            r_xfer_req  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_REQ_HI;
                        end
                    end
                    S_REQ_HI: begin
                        if (w_ack_s) begin
                            r_xfer_req <= 1'b0;
                            r_state    <= S_REQ_LO;
                        end
                    end
                    S_REQ_LO: begin
                        if (!w_ack_s) begin
                            r_grant[r_win_id] <= 1'b1;
                            r_rr_ptr          <= w_win_next;
                            r_busy            <= 1'b0;
                            r_state           <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign xfer_req  = r_xfer_req;
    assign xfer_data = r_xfer_data;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Randomized bench for cdc_xfer_arbiter with a transaction-level reference model and far-side ack responder.
// Directed scenarios first, then random requesters; define XFER_TIMEOUT_EN to also exercise the abort path.
module tb_cdc_xfer_arbiter;
    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
`ifdef XFER_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 255;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    xfer_req;
    logic [DATA_W-1:0]       xfer_data;
    logic                    xfer_ack_async;
    logic                    err;
    logic [1:0]              err_id;

    always #5 clk = ~clk;

    cdc_xfer_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
        .busy(busy), .xfer_req(xfer_req), .xfer_data(xfer_data),
        .xfer_ack_async(xfer_ack_async), .err(err), .err_id(err_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: transfer-level view of the channel.
    int               m_rr;
    bit               m_inflight;
    bit               m_ack_seen;
    int               m_win;
    int               m_age;
    logic [DATA_W-1:0] m_data;
    logic             m_hist [SYNC_STAGES];
    int               m_wait [N_REQ];
    logic [N_REQ-1:0] e_grant;
    bit               e_xreq;
    bit               e_err;
    int               e_err_id;

    int   gq[$];
    int   cyc = 0;
    int   err_cyc = -1;
    int   launch_cyc = -1;
    bit   auto_req = 1'b0;
    int   far_mode = 0;
    int   far_cnt = 0;
    int   far_dly = 2;
    int   far_lo = 1;
    int   far_hi = 4;

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_inflight = 0; m_ack_seen = 0; m_win = 0; m_age = 0; m_data = '0;
        e_grant = '0; e_xreq = 0; e_err = 0; e_err_id = 0;
        for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] = 1'b0;
        for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
    endtask

    task automatic model_edge(input logic [N_REQ-1:0] r, input logic [N_REQ*DATA_W-1:0] d, input logic a);
        logic acks;
        acks = m_hist[SYNC_STAGES-1];
        for (int k = SYNC_STAGES-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = a;
        e_grant = '0;
        e_err   = 0;
        for (int i = 0; i < N_REQ; i++) if (!r[i]) m_wait[i] = 0;
        if (!m_inflight) begin
            if (r != '0 && !acks) begin
                m_win = rr_pick(r, m_rr);
                m_data = d[m_win*DATA_W +: DATA_W];
                m_inflight = 1; m_ack_seen = 0; m_age = 0; e_xreq = 1;
            end
        end else begin
            m_age++;
            if (!m_ack_seen) begin
                if (acks) begin m_ack_seen = 1; e_xreq = 0; end
            end else if (!acks) begin
                e_grant[m_win] = 1'b1;
                for (int i = 0; i < N_REQ; i++) if (i != m_win && r[i]) m_wait[i]++;
                check_eq("starvation_bound", (m_wait[m_win] <= N_REQ-1), 1);
                m_wait[m_win] = 0;
                m_rr = (m_win + 1) % N_REQ;
                m_inflight = 0;
            end
`ifdef XFER_TIMEOUT_EN
            if (m_inflight && m_age == TMO) begin
                e_err = 1; e_err_id = m_win; e_xreq = 0;
                m_wait[m_win] = 0;
                m_rr = (m_win + 1) % N_REQ;
                m_inflight = 0;
            end
`endif
        end
    endtask

    task automatic check_outputs();
        check_eq("xfer_req", xfer_req, e_xreq);
        check_eq("busy", busy, m_inflight);
        check_eq("grant", grant, e_grant);
        check_eq("xfer_data", xfer_data, m_data);
        check_eq("err", err, e_err);
        check_eq("err_id", err_id, e_err_id);
    endtask

    task automatic drive_next();
        req = req & ~grant;
        if (auto_req) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && !(m_inflight && m_win == i) && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) req_data = {$urandom, $urandom};
            if (m_inflight && $urandom_range(0, 15) == 0) req[m_win] = 1'b0;
        end
        case (far_mode)
            1: xfer_ack_async = 1'b1;
            2: xfer_ack_async = 1'b0;
            default: begin
                if (xfer_ack_async != xfer_req) begin
                    far_cnt++;
                    if (far_cnt >= far_dly) begin
                        xfer_ack_async = xfer_req;
                        far_cnt = 0;
                        far_dly = $urandom_range(far_lo, far_hi);
                    end
                end else begin
                    far_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic step();
        logic [N_REQ-1:0]        r_in;
        logic [N_REQ*DATA_W-1:0] d_in;
        logic                    a_in;
        logic                    rs;
        @(posedge clk);
        r_in = req; d_in = req_data; a_in = xfer_ack_async; rs = rst_n;
        #1;
        cyc++;
        if (rs) model_edge(r_in, d_in, a_in);
        else    model_reset();
        check_outputs();
        for (int i = 0; i < N_REQ; i++) if (grant[i]) gq.push_back(i);
        if (err) err_cyc = cyc;
        if (e_xreq && m_age == 0 && m_inflight) launch_cyc = cyc;
        drive_next();
    endtask

    task automatic run_until_idle(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            if (!m_inflight && req == '0) return;
            step();
        end
        check_eq("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; xfer_ack_async = 1'b0;
        model_reset();
        step();
        check_eq("rst_xfer_req", xfer_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_xfer_data", xfer_data, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single request, far side acks 3 cycles after seeing xfer_req.
        far_lo = 3; far_hi = 3; far_dly = 3;
        gq.delete();
        req_data[2*DATA_W +: DATA_W] = 8'hA5;
        req = 4'b0100;
        step();
        check_eq("t1_xreq_next_cycle", xfer_req, 1);
        check_eq("t1_data", xfer_data, 8'hA5);
        run_until_idle(100);
        check_eq("t1_grant_count", gq.size(), 1);
        if (gq.size() > 0) check_eq("t1_grant_id", gq[0], 2);
        step();
        check_eq("t1_busy_after", busy, 0);

        // Round-robin order from a fresh pointer.
        far_lo = 1; far_hi = 4;
        do_reset();
        gq.delete();
        req_data = {$urandom, $urandom};
        req = 4'b1111;
        run_until_idle(200);
        check_eq("t2_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) check_eq("t2_order", gq[i], i);
        gq.delete();
        req = 4'b1001;
        run_until_idle(200);
        check_eq("t2b_count", gq.size(), 2);
        if (gq.size() == 2) begin
            check_eq("t2b_first", gq[0], 0);
            check_eq("t2b_second", gq[1], 3);
        end

        // Data and req change while in flight.
        gq.delete();
        far_lo = 5; far_hi = 5; far_dly = 5;
        req_data[0 +: DATA_W] = 8'h3C;
        req = 4'b0001;
        step();
        step();
        req_data = {$urandom, $urandom};
        req = 4'b0000;
        step();
        check_eq("t3_data_held", xfer_data, 8'h3C);
        run_until_idle(100);
        check_eq("t3_grant_count", gq.size(), 1);
        if (gq.size() > 0) check_eq("t3_grant_id", gq[0], 0);

        // Stale ack out of reset.
        far_lo = 1; far_hi = 4;
        far_mode = 1;
        xfer_ack_async = 1'b1;
        do_reset();
        gq.delete();
        req = 4'b0001;
        repeat (8) step();
        check_eq("t4_no_launch", xfer_req, 0);
        far_mode = 0; far_cnt = 0; far_dly = 2;
        run_until_idle(100);
        check_eq("t4_grant_count", gq.size(), 1);
        if (gq.size() > 0) check_eq("t4_grant_id", gq[0], 0);

        // Reset while waiting for ack to fall.
        far_lo = 4; far_hi = 4; far_dly = 4;
        gq.delete();
        req = 4'b0100;
        for (int k = 0; k < 50; k++) begin
            if (m_inflight && m_ack_seen) break;
            step();
        end
        check_eq("t5_reached_req_lo", (m_inflight && m_ack_seen), 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_xreq_now", xfer_req, 0);
        check_eq("t5_busy_now", busy, 0);
        check_eq("t5_grant_now", grant, 0);
        step();
        step();
        rst_n = 1'b1;
        far_lo = 1; far_hi = 4;
        check_eq("t5_no_grant", gq.size(), 0);
        req = 4'b1100;
        run_until_idle(200);
        check_eq("t5_count", gq.size(), 2);
        if (gq.size() > 0) check_eq("t5_first_after_rst", gq[0], 2);

`ifdef XFER_TIMEOUT_EN
        // Never-acked launch aborts after TMO cycles.
        far_mode = 2;
        xfer_ack_async = 1'b0;
        do_reset();
        gq.delete();
        err_cyc = -1; launch_cyc = -1;
        req = 4'b0110;
        for (int k = 0; k < 80; k++) begin
            if (err_cyc >= 0) break;
            step();
        end
        check_eq("t6_err_seen", (err_cyc >= 0), 1);
        check_eq("t6_err_delay", err_cyc - launch_cyc, TMO);
        check_eq("t6_err_id", err_id, 1);
        check_eq("t6_xreq_low", xfer_req, 0);
        check_eq("t6_no_grant", gq.size(), 0);
        far_mode = 0; far_cnt = 0;
        run_until_idle(200);
        check_eq("t6_count", gq.size(), 2);
        if (gq.size() > 0) check_eq("t6_next_served", gq[0], 2);
`endif

        // Random traffic.
        far_mode = 0; far_lo = 1; far_hi = 4;
        gq.delete();
        auto_req = 1'b1;
        repeat (1500) step();
        auto_req = 1'b0;
        run_until_idle(300);
        check_eq("rand_some_grants", (gq.size() > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
